// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, data width, default bit period.
// Used by uart_rx and uart_tx.
package uart_pkg;

  localparam int unsigned UART_DATA_W       = 8;
  localparam int unsigned UART_CLKS_PER_BIT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer on the serial line plus a previous-sample flop
// for falling-edge detection. All flops reset to the idle-high level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  output logic rx_s,
  output logic fall
);

  logic rx_meta;
  logic rx_sync;
  logic rx_d;

  // Synchronize rxd into clk and keep one cycle of history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_d    <= rx_sync;
    end
  end

  assign rx_s = rx_sync;
  assign fall = rx_d & ~rx_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data (LSB first), 1 stop, no parity.
// Samples each bit at mid-bit using a down-counter of CLKS_PER_BIT clocks.
// Optional macro UART_RX_FRAME_ERR_EN enables the stop-bit check; when
// undefined every frame is delivered and frame_err is tied low.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rxd,
  output logic [UART_DATA_W-1:0] data,
  output logic                   valid,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  uart_state_e            state;
  uart_state_e            state_nxt;
  logic                   rx_s;
  logic                   fall;
  logic [CW-1:0]          clk_cnt;
  logic [2:0]             bit_cnt;
  logic [UART_DATA_W-1:0] shreg;
  logic                   cnt_zero;
  logic                   stop_done;
  logic                   stop_ok;
  logic                   valid_nxt;
  logic                   busy_nxt;
  logic [UART_DATA_W-1:0] data_nxt;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rxd   (rxd),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  assign cnt_zero  = (clk_cnt == '0);
  assign stop_done = (state == STOP) && cnt_zero;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fall) state_nxt = START;
      START: if (cnt_zero) state_nxt = rx_s ? IDLE : DATA;
      DATA:  if (cnt_zero && (bit_cnt == 3'd7)) state_nxt = STOP;
      STOP:  if (cnt_zero) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bit-timing counter, bit counter and receive shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fall) clk_cnt <= HALF_LOAD;
        end
        START: begin
          if (cnt_zero) begin
            clk_cnt <= FULL_LOAD;
            bit_cnt <= '0;
          end else begin
            clk_cnt <= clk_cnt - CW'(1);
          end
        end
        DATA: begin
          if (cnt_zero) begin
            shreg   <= {rx_s, shreg[UART_DATA_W-1:1]};
            clk_cnt <= FULL_LOAD;
            bit_cnt <= bit_cnt + 3'd1;
          end else begin
            clk_cnt <= clk_cnt - CW'(1);
          end
        end
        STOP: begin
          if (!cnt_zero) clk_cnt <= clk_cnt - CW'(1);
        end
        default: clk_cnt <= '0;
      endcase
    end
  end

`ifdef UART_RX_FRAME_ERR_EN
  assign stop_ok = rx_s;

  // Frame-error strobe when the stop bit samples low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err <= 1'b0;
    else        frame_err <= stop_done & ~stop_ok;
  end
`else
  assign stop_ok   = 1'b1;
  assign frame_err = 1'b0;
`endif

  // Next values of the registered outputs
  always_comb begin
    valid_nxt = stop_done & stop_ok;
    busy_nxt  = (state_nxt != IDLE);
    data_nxt  = valid_nxt ? shreg : data;
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      data  <= data_nxt;
      valid <= valid_nxt;
      busy  <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at CLKS_PER_BIT=16.
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  int unsigned cyc      = 0;
  int unsigned ferr_cnt = 0;
  int unsigned both_cnt = 0;
  logic        busy_prev = 1'b0;

  logic [7:0]  vq[$];
  int unsigned vt[$];
  logic        vbusy[$];
  logic        vbprev[$];
  logic [7:0]  exp_q[$];

  uart_rx #(.CLKS_PER_BIT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (valid) begin
      vq.push_back(data);
      vt.push_back(cyc);
      vbusy.push_back(busy);
      vbprev.push_back(busy_prev);
    end
    if (frame_err) ferr_cnt++;
    if (valid && frame_err) both_cnt++;
    busy_prev = busy;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Serial transmitter model; mode 0 nominal, 1 about +3%, 2 about -3%
  task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                           input int unsigned mode, output int unsigned fall_c);
    logic        v;
    int unsigned len;
    fall_c = cyc;
    for (int unsigned i = 0; i < 10; i++) begin
      if (i == 0)      v = 1'b0;
      else if (i == 9) v = stop_bit;
      else             v = b[i-1];
      len = 16;
      if (mode == 1 && (i % 2) == 1) len = 17;
      if (mode == 2 && (i % 2) == 1) len = 15;
      rxd = v;
      repeat (len) @(negedge clk);
    end
  endtask

  initial begin
    int unsigned fc;
    int unsigned n0;
    int unsigned f0;
    logic [7:0]  b;

    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data",  32'(data), 32'h00);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_ferr",  32'(frame_err), 32'h0);
    chk("reset_busy",  32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0xA5, nominal timing
    n0 = vq.size();
    send_byte(8'hA5, 1'b1, 0, fc);
    repeat (10) @(negedge clk);
    chk("a5_count", vq.size() - n0, 1);
    if (vq.size() > n0) begin
      chk("a5_data",      32'(vq[n0]), 32'hA5);
      chk("a5_latency",   vt[n0] - fc, 155);
      chk("a5_busy_at_v", 32'(vbusy[n0]), 32'h0);
      chk("a5_busy_prev", 32'(vbprev[n0]), 32'h1);
    end
    chk("a5_hold", 32'(data), 32'hA5);

    // Start glitch: low for 3 cycles
    n0 = vq.size();
    f0 = ferr_cnt;
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    chk("glitch_busy_hi", 32'(busy), 32'h1);
    repeat (5) @(negedge clk);
    chk("glitch_busy_lo", 32'(busy), 32'h0);
    repeat (20) @(negedge clk);
    chk("glitch_no_valid", vq.size() - n0, 0);
    chk("glitch_no_ferr",  ferr_cnt - f0, 0);
    chk("glitch_data",     32'(data), 32'hA5);

    // 0x3C with the stop bit low
    n0 = vq.size();
    f0 = ferr_cnt;
    send_byte(8'h3C, 1'b0, 0, fc);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
`ifdef UART_RX_FRAME_ERR_EN
    chk("stop0_ferr",     ferr_cnt - f0, 1);
    chk("stop0_no_valid", vq.size() - n0, 0);
    chk("stop0_data",     32'(data), 32'hA5);
`else
    chk("stop0_ferr",  ferr_cnt - f0, 0);
    chk("stop0_valid", vq.size() - n0, 1);
    chk("stop0_data",  32'(data), 32'h3C);
`endif

    // Back-to-back frames, no idle gap
    n0 = vq.size();
    f0 = ferr_cnt;
    send_byte(8'h00, 1'b1, 0, fc);
    send_byte(8'hFF, 1'b1, 0, fc);
    send_byte(8'h55, 1'b1, 0, fc);
    repeat (20) @(negedge clk);
    chk("b2b_count", vq.size() - n0, 3);
    if (vq.size() >= n0 + 3) begin
      chk("b2b_byte0", 32'(vq[n0]),   32'h00);
      chk("b2b_byte1", 32'(vq[n0+1]), 32'hFF);
      chk("b2b_byte2", 32'(vq[n0+2]), 32'h55);
      chk("b2b_gap01", vt[n0+1] - vt[n0],   160);
      chk("b2b_gap12", vt[n0+2] - vt[n0+1], 160);
    end
    chk("b2b_no_ferr", ferr_cnt - f0, 0);

    // Reset during data bit 4 of 0x6C
    n0 = vq.size();
    f0 = ferr_cnt;
    b  = 8'h6C;
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int unsigned i = 0; i < 4; i++) begin
      rxd = b[i];
      repeat (16) @(negedge clk);
    end
    rxd = b[4];
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    repeat (8) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid_data", 32'(data), 32'h00);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("rst_mid_no_valid", vq.size() - n0, 0);
    chk("rst_mid_no_ferr",  ferr_cnt - f0, 0);
    send_byte(8'h81, 1'b1, 0, fc);
    repeat (10) @(negedge clk);
    chk("after_rst_count", vq.size() - n0, 1);
    chk("after_rst_data",  32'(data), 32'h81);

    // Random bytes with +/-3% bit-period skew
    n0 = vq.size();
    f0 = ferr_cnt;
    for (int unsigned i = 0; i < 256; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_byte(b, 1'b1, i % 3, fc);
    end
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk("skew_count",   vq.size() - n0, 256);
    chk("skew_no_ferr", ferr_cnt - f0, 0);
    if (vq.size() >= n0 + 256) begin
      for (int unsigned i = 0; i < 256; i++)
        chk("skew_byte", 32'(vq[n0+i]), 32'(exp_q[i]));
    end

    chk("valid_ferr_exclusive", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
